// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART command frame parser.
package uart_cmd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_CHK,
      ST_EXEC,
      ST_RD_WAIT,
      ST_RESP0,
      ST_RESP1
   } state_e;

   localparam logic [7:0] CMD_WR   = 8'h01;
   localparam logic [7:0] CMD_RD   = 8'h02;
   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Idle-cycle counter for an open frame; reloads to zero on clear and flags
// expiry on the LIMIT-th consecutive enabled cycle.
module uart_cmd_timeout #(
   parameter int LIMIT = 20000
) (
   input  logic in_clk,
   input  logic in_rst,
   input  logic in_clear,
   input  logic in_enable,
   output logic out_expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign out_expire = in_enable && !in_clear && (cnt_q == CW'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (in_clear || out_expire) begin
         cnt_d = '0;
      end else if (in_enable) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/CMD/ADDR/DATA/CHK frames from the UART receiver, drives the
// register bank port and returns ACK/NAK (plus read data) to the transmitter.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         ADDR_W      = 4,
   parameter int         TIMEOUT_CYC = 20000
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_rx_ready,
   input  logic [7:0]        in_rx_data,
   output logic              out_wr_en,
   output logic [ADDR_W-1:0] out_wr_addr,
   output logic [7:0]        out_wr_data,
   output logic              out_rd_en,
   output logic [ADDR_W-1:0] out_rd_addr,
   input  logic              in_rd_valid,
   input  logic [7:0]        in_rd_data,
   output logic              out_tx_valid,
   output logic [7:0]        out_tx_data,
   input  logic              in_tx_ready,
   output logic              out_busy,
   output logic [7:0]        out_err_cnt
);

   state_e            state_q, state_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic [7:0]        xor_q, xor_d;
   logic              chk_ok_q, chk_ok_d;
   logic              two_byte_q, two_byte_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic in_frame;
   logic tmo_clear;
   logic tmo_enable;
   logic tmo_expire;
   logic frame_ok;
   logic err_event;

   assign in_frame   = state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK};
   assign tmo_enable = in_frame && !in_rx_ready;
   assign tmo_clear  = !in_frame || in_rx_ready;
   assign frame_ok   = chk_ok_q && ((cmd_q == CMD_WR) || (cmd_q == CMD_RD));

   uart_cmd_timeout #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout (
      .in_clk     (in_clk),
      .in_rst     (in_rst),
      .in_clear   (tmo_clear),
      .in_enable  (tmo_enable),
      .out_expire (tmo_expire)
   );

   // The checksum is folded in as bytes arrive so only ADDR_W address bits need storing.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      data_d     = data_q;
      xor_d      = xor_q;
      chk_ok_d   = chk_ok_q;
      two_byte_d = two_byte_q;
      rd_data_d  = rd_data_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      err_event  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_rx_ready && (in_rx_data == SYNC_BYTE)) begin
               xor_d   = '0;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            if (in_rx_ready) begin
               cmd_d   = in_rx_data;
               xor_d   = xor_q ^ in_rx_data;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (in_rx_ready) begin
               addr_d  = in_rx_data[ADDR_W-1:0];
               xor_d   = xor_q ^ in_rx_data;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (in_rx_ready) begin
               data_d  = in_rx_data;
               xor_d   = xor_q ^ in_rx_data;
               state_d = ST_CHK;
            end
         end
         ST_CHK: begin
            if (in_rx_ready) begin
               chk_ok_d = (xor_q == in_rx_data);
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            two_byte_d = 1'b0;
            if (!frame_ok) begin
               err_event  = 1'b1;
               tx_data_d  = NAK_BYTE;
               tx_valid_d = 1'b1;
               state_d    = ST_RESP0;
            end else if (cmd_q == CMD_WR) begin
               tx_data_d  = ACK_BYTE;
               tx_valid_d = 1'b1;
               state_d    = ST_RESP0;
            end else begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (in_rd_valid) begin
               rd_data_d  = in_rd_data;
               two_byte_d = 1'b1;
               tx_data_d  = ACK_BYTE;
               tx_valid_d = 1'b1;
               state_d    = ST_RESP0;
            end
         end
         ST_RESP0: begin
            if (in_tx_ready) begin
               if (two_byte_q) begin
                  tx_data_d = rd_data_q;
                  state_d   = ST_RESP1;
               end else begin
                  tx_valid_d = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end
         ST_RESP1: begin
            if (in_tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Expiry can only fire while a frame is open and no byte arrived this cycle.
      if (tmo_expire) begin
         state_d   = ST_IDLE;
         err_event = 1'b1;
      end

      if (in_rx_ready && (state_q inside {ST_EXEC, ST_RD_WAIT, ST_RESP0, ST_RESP1})) begin
         err_event = 1'b1;
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_event && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         xor_q      <= '0;
         chk_ok_q   <= 1'b0;
         two_byte_q <= 1'b0;
         rd_data_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         xor_q      <= xor_d;
         chk_ok_q   <= chk_ok_d;
         two_byte_q <= two_byte_d;
         rd_data_q  <= rd_data_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign out_wr_en    = (state_q == ST_EXEC) && chk_ok_q && (cmd_q == CMD_WR);
   assign out_rd_en    = (state_q == ST_EXEC) && chk_ok_q && (cmd_q == CMD_RD);
   assign out_wr_addr  = addr_q;
   assign out_wr_data  = data_q;
   assign out_rd_addr  = addr_q;
   assign out_tx_valid = tx_valid_q;
   assign out_tx_data  = tx_data_q;
   assign out_busy     = (state_q != ST_IDLE);
   assign out_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized and directed bench for uart_cmd_ctrl against a frame-level
// model of expected writes, reads, response bytes and error count.
module tb_uart_cmd_ctrl;

   localparam int TIMEOUT_CYC = 20000;
   localparam int WAIT_LIMIT  = 4000;

   logic       in_clk;
   logic       in_rst;
   logic       in_rx_ready;
   logic [7:0] in_rx_data;
   logic       out_wr_en;
   logic [3:0] out_wr_addr;
   logic [7:0] out_wr_data;
   logic       out_rd_en;
   logic [3:0] out_rd_addr;
   logic       in_rd_valid;
   logic [7:0] in_rd_data;
   logic       out_tx_valid;
   logic [7:0] out_tx_data;
   logic       in_tx_ready;
   logic       out_busy;
   logic [7:0] out_err_cnt;

   uart_cmd_ctrl #(
      .SYNC_BYTE   (8'hA5),
      .ADDR_W      (4),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .in_clk       (in_clk),
      .in_rst       (in_rst),
      .in_rx_ready  (in_rx_ready),
      .in_rx_data   (in_rx_data),
      .out_wr_en    (out_wr_en),
      .out_wr_addr  (out_wr_addr),
      .out_wr_data  (out_wr_data),
      .out_rd_en    (out_rd_en),
      .out_rd_addr  (out_rd_addr),
      .in_rd_valid  (in_rd_valid),
      .in_rd_data   (in_rd_data),
      .out_tx_valid (out_tx_valid),
      .out_tx_data  (out_tx_data),
      .in_tx_ready  (in_tx_ready),
      .out_busy     (out_busy),
      .out_err_cnt  (out_err_cnt)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [11:0] exp_wr_q[$];
   logic [3:0]  exp_rd_q[$];
   logic [7:0]  exp_tx_q[$];
   int          exp_err = 0;

   int         rd_lat     = 3;
   logic [7:0] rd_value   = 8'h00;
   int         ready_mode = 0;

   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag_fail(input string name, input string info);
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: %s (t=%0t)", name, info, $time);
   endtask

   task automatic err_bump();
      if (exp_err < 255) exp_err++;
   endtask

   // Frame-level rules: checksum is the XOR of CMD, ADDR, DATA; only 01/02 are commands.
   task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] data, input logic [7:0] chk,
                              input logic [7:0] rdv);
      logic ok;
      ok = ((cmd ^ addr ^ data) == chk) && (cmd == 8'h01 || cmd == 8'h02);
      if (!ok) begin
         exp_tx_q.push_back(8'h15);
         err_bump();
      end else if (cmd == 8'h01) begin
         exp_wr_q.push_back({addr[3:0], data});
         exp_tx_q.push_back(8'h06);
      end else begin
         exp_rd_q.push_back(addr[3:0]);
         exp_tx_q.push_back(8'h06);
         exp_tx_q.push_back(rdv);
      end
   endtask

   // Single compare process: bank port events and transmitter handshakes against the model.
   initial begin
      forever begin
         @(negedge in_clk);
         if (in_rst === 1'b1) begin
            if (out_wr_en === 1'b1) begin
               if (exp_wr_q.size() == 0) flag_fail("wr_unexpected", $sformatf("addr %0h data %0h", out_wr_addr, out_wr_data));
               else check_output("wr_addr_data", 32'({out_wr_addr, out_wr_data}), 32'(exp_wr_q.pop_front()));
            end
            if (out_rd_en === 1'b1) begin
               if (exp_rd_q.size() == 0) flag_fail("rd_unexpected", $sformatf("addr %0h", out_rd_addr));
               else check_output("rd_addr", 32'(out_rd_addr), 32'(exp_rd_q.pop_front()));
            end
            if (prev_valid && !prev_ready) begin
               check_output("tx_valid_hold", 32'(out_tx_valid), 32'd1);
               check_output("tx_data_hold", 32'(out_tx_data), 32'(prev_data));
            end
            if (out_tx_valid === 1'b1 && in_tx_ready === 1'b1) begin
               if (exp_tx_q.size() == 0) flag_fail("tx_unexpected", $sformatf("byte %0h", out_tx_data));
               else check_output("tx_byte", 32'(out_tx_data), 32'(exp_tx_q.pop_front()));
            end
            prev_valid = out_tx_valid;
            prev_ready = in_tx_ready;
            prev_data  = out_tx_data;
         end else begin
            prev_valid = 1'b0;
         end
      end
   end

   initial begin
      in_tx_ready = 1'b0;
      forever begin
         @(posedge in_clk);
         #1;
         case (ready_mode)
            0:       in_tx_ready = 1'b1;
            1:       in_tx_ready = ($urandom_range(0, 99) < 60);
            default: in_tx_ready = 1'b0;
         endcase
      end
   end

   // Register bank stand-in: answers each read request after rd_lat cycles.
   initial begin
      in_rd_valid = 1'b0;
      in_rd_data  = 8'h00;
      forever begin
         @(negedge in_clk);
         if (in_rst === 1'b1 && out_rd_en === 1'b1) begin
            @(posedge in_clk);
            #1;
            repeat (rd_lat - 1) begin
               @(posedge in_clk);
               #1;
            end
            in_rd_valid = 1'b1;
            in_rd_data  = rd_value;
            @(posedge in_clk);
            #1;
            in_rd_valid = 1'b0;
            in_rd_data  = 8'($urandom);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge in_clk);
         #1;
      end
   endtask

   task automatic apply_byte(input logic [7:0] b);
      in_rx_ready = 1'b1;
      in_rx_data  = b;
      @(posedge in_clk);
      #1;
      in_rx_ready = 1'b0;
      in_rx_data  = 8'($urandom);
   endtask

   task automatic apply_frame(input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input int max_gap);
      apply_byte(8'hA5);
      idle($urandom_range(0, max_gap));
      apply_byte(b1);
      idle($urandom_range(0, max_gap));
      apply_byte(b2);
      idle($urandom_range(0, max_gap));
      apply_byte(b3);
      idle($urandom_range(0, max_gap));
      apply_byte(b4);
   endtask

   task automatic wait_idle(input string tag);
      int cnt;
      cnt = 0;
      @(negedge in_clk);
      while (out_busy === 1'b1 && cnt < WAIT_LIMIT) begin
         @(negedge in_clk);
         cnt++;
      end
      n_checks++;
      if (out_busy !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL %s_idle: busy is %b after %0d cycles, required 0", tag, out_busy, cnt);
      end
      @(posedge in_clk);
      #1;
   endtask

   task automatic wait_tx_valid(input string tag);
      int cnt;
      cnt = 0;
      @(negedge in_clk);
      while (out_tx_valid !== 1'b1 && cnt < 200) begin
         @(negedge in_clk);
         cnt++;
      end
      check_output({tag, "_tx_valid"}, 32'(out_tx_valid), 32'd1);
      @(posedge in_clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check_output({tag, "_err_cnt"}, 32'(out_err_cnt), 32'(exp_err));
      check_output({tag, "_tx_left"}, 32'(exp_tx_q.size()), 32'd0);
      check_output({tag, "_wr_left"}, 32'(exp_wr_q.size()), 32'd0);
      check_output({tag, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
   endtask

   // Asserted mid-cycle so the outputs must fall without a clock edge.
   task automatic async_reset(input string tag);
      #2;
      in_rst = 1'b0;
      #1;
      check_output({tag, "_busy"}, 32'(out_busy), 32'd0);
      check_output({tag, "_tx_valid"}, 32'(out_tx_valid), 32'd0);
      check_output({tag, "_wr_en"}, 32'(out_wr_en), 32'd0);
      check_output({tag, "_rd_en"}, 32'(out_rd_en), 32'd0);
      check_output({tag, "_err_cnt"}, 32'(out_err_cnt), 32'd0);
      exp_wr_q.delete();
      exp_rd_q.delete();
      exp_tx_q.delete();
      exp_err = 0;
      @(posedge in_clk);
      @(posedge in_clk);
      #2;
      in_rst = 1'b1;
      @(posedge in_clk);
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks + 1, n_errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] c, a, d, k, g;
      int         ng, sel;

      in_rst      = 1'b1;
      in_rx_ready = 1'b0;
      in_rx_data  = 8'h00;
      #3;
      in_rst = 1'b0;
      #1;
      check_output("reset_busy", 32'(out_busy), 32'd0);
      check_output("reset_tx_valid", 32'(out_tx_valid), 32'd0);
      check_output("reset_tx_data", 32'(out_tx_data), 32'd0);
      check_output("reset_wr_en", 32'(out_wr_en), 32'd0);
      check_output("reset_rd_en", 32'(out_rd_en), 32'd0);
      check_output("reset_err_cnt", 32'(out_err_cnt), 32'd0);
      @(posedge in_clk);
      @(posedge in_clk);
      #2;
      in_rst = 1'b1;
      @(posedge in_clk);
      #1;

      $display("[TB] directed write");
      exp_wr_q.push_back({4'h3, 8'h5C});
      exp_tx_q.push_back(8'h06);
      apply_frame(8'h01, 8'h03, 8'h5C, 8'h5E, 0);
      @(negedge in_clk);
      check_output("t1_wr_en", 32'(out_wr_en), 32'd1);
      check_output("t1_wr_addr", 32'(out_wr_addr), 32'h3);
      check_output("t1_wr_data", 32'(out_wr_data), 32'h5C);
      @(negedge in_clk);
      check_output("t1_wr_en_pulse", 32'(out_wr_en), 32'd0);
      wait_idle("t1");
      check_output("t1_err_lit", 32'(out_err_cnt), 32'd0);
      check_quiet("t1");

      $display("[TB] directed read");
      rd_value = 8'h9C;
      rd_lat   = 3;
      exp_rd_q.push_back(4'h7);
      exp_tx_q.push_back(8'h06);
      exp_tx_q.push_back(8'h9C);
      apply_frame(8'h02, 8'h07, 8'h00, 8'h05, 0);
      @(negedge in_clk);
      check_output("t2_rd_en", 32'(out_rd_en), 32'd1);
      check_output("t2_rd_addr", 32'(out_rd_addr), 32'h7);
      wait_idle("t2");
      check_quiet("t2");

      $display("[TB] directed bad checksum");
      exp_tx_q.push_back(8'h15);
      exp_err = 1;
      apply_frame(8'h01, 8'h03, 8'h5C, 8'h00, 0);
      wait_idle("t3");
      check_output("t3_err_lit", 32'(out_err_cnt), 32'd1);
      check_quiet("t3");

      $display("[TB] random frames");
      ready_mode = 1;
      for (int i = 0; i < 40; i++) begin
         ng = $urandom_range(0, 2);
         for (int j = 0; j < ng; j++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            apply_byte(g);
            idle($urandom_range(0, 2));
         end
         sel = $urandom_range(0, 9);
         if (sel < 4)      c = 8'h01;
         else if (sel < 8) c = 8'h02;
         else              c = 8'($urandom);
         a = 8'($urandom);
         d = 8'($urandom);
         k = c ^ a ^ d;
         if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
         rd_lat   = $urandom_range(1, 6);
         rd_value = 8'($urandom);
         model_frame(c, a, d, k, rd_value);
         apply_frame(c, a, d, k, 3);
         wait_idle("rand");
         check_quiet("rand");
      end
      ready_mode = 0;

      $display("[TB] longest legal gap");
      exp_wr_q.push_back({4'hC, 8'h77});
      exp_tx_q.push_back(8'h06);
      apply_byte(8'hA5);
      apply_byte(8'h01);
      idle(TIMEOUT_CYC - 1);
      apply_byte(8'h0C);
      apply_byte(8'h77);
      apply_byte(8'h7A);
      wait_idle("gap");
      check_quiet("gap");

      $display("[TB] timeout");
      apply_byte(8'hA5);
      apply_byte(8'h01);
      idle(TIMEOUT_CYC - 1);
      @(negedge in_clk);
      check_output("tmo_busy_before", 32'(out_busy), 32'd1);
      @(posedge in_clk);
      #1;
      err_bump();
      @(negedge in_clk);
      check_output("tmo_busy_after", 32'(out_busy), 32'd0);
      check_output("tmo_tx_valid", 32'(out_tx_valid), 32'd0);
      @(posedge in_clk);
      #1;
      check_quiet("tmo");
      exp_wr_q.push_back({4'h3, 8'h5C});
      exp_tx_q.push_back(8'h06);
      apply_frame(8'h01, 8'h03, 8'h5C, 8'h5E, 0);
      wait_idle("tmo_next");
      check_quiet("tmo_next");

      $display("[TB] transmitter stall during read response");
      ready_mode = 2;
      rd_value   = 8'h9C;
      rd_lat     = 3;
      exp_rd_q.push_back(4'h7);
      exp_tx_q.push_back(8'h06);
      exp_tx_q.push_back(8'h9C);
      apply_frame(8'h02, 8'h07, 8'h00, 8'h05, 0);
      wait_tx_valid("stall");
      check_output("stall_first_byte", 32'(out_tx_data), 32'h06);
      idle(20);
      apply_byte(8'h33);
      err_bump();
      idle(29);
      check_output("stall_still_valid", 32'(out_tx_valid), 32'd1);
      check_output("stall_still_ack", 32'(out_tx_data), 32'h06);
      ready_mode = 0;
      wait_idle("stall");
      check_quiet("stall");

      $display("[TB] error counter saturation");
      ready_mode = 2;
      exp_wr_q.push_back({4'hA, 8'h11});
      exp_tx_q.push_back(8'h06);
      apply_frame(8'h01, 8'h0A, 8'h11, 8'h1A, 0);
      wait_tx_valid("sat");
      for (int i = 0; i < 260; i++) begin
         apply_byte(8'($urandom));
         err_bump();
      end
      check_output("sat_err_lit", 32'(out_err_cnt), 32'hFF);
      ready_mode = 0;
      wait_idle("sat");
      check_quiet("sat");

      $display("[TB] reset during DATA");
      apply_byte(8'hA5);
      apply_byte(8'h01);
      apply_byte(8'h03);
      async_reset("rst_data");
      apply_byte(8'h5C);
      apply_byte(8'h5E);
      idle(3);
      exp_wr_q.push_back({4'h5, 8'hC3});
      exp_tx_q.push_back(8'h06);
      apply_frame(8'h01, 8'h05, 8'hC3, 8'hC7, 1);
      wait_idle("rst_data_next");
      check_quiet("rst_data_next");

      $display("[TB] reset during RESP0");
      ready_mode = 2;
      rd_value   = 8'h4E;
      rd_lat     = 2;
      exp_rd_q.push_back(4'h7);
      exp_tx_q.push_back(8'h06);
      exp_tx_q.push_back(8'h4E);
      apply_frame(8'h02, 8'h07, 8'h00, 8'h05, 0);
      wait_tx_valid("rst_resp");
      async_reset("rst_resp");
      ready_mode = 0;
      exp_wr_q.push_back({4'h9, 8'h3C});
      exp_tx_q.push_back(8'h06);
      apply_frame(8'h01, 8'h09, 8'h3C, 8'h34, 1);
      wait_idle("rst_resp_next");
      check_output("rst_resp_err_lit", 32'(out_err_cnt), 32'd0);
      check_quiet("rst_resp_next");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
